codeword_framer: RTL and testbench

- Downstream neighbour of the block turbo encoder.
- Accepts 32-bit encoded codewords over a valid/ready handshake and buffers them in a small FIFO.
- Emits each codeword as a serial bit stream, MSB first, preceded by a fixed sync header.
- Feeds the serial channel/modulator interface; the matching deframer on the receive side rebuilds the 32-bit received_data word for the decoder.

---
 rtl/framer_pkg.sv | 17 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/codeword_framer.sv | 158 +++++++++++++++
 tb/tb_codeword_framer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/framer_pkg.sv
// Shared types and defaults for the codeword framer/deframer pair.
// Header pattern and widths must match on both sides of the link.
package framer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA
  } state_e;

  localparam int DEF_CW_W = 32;
  localparam int DEF_SYNC_W = 8;
  localparam logic [7:0] DEF_SYNC_PATTERN = 8'hB8;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head is the registered entry at the read pointer.
// Pop takes effect on the same edge it is asserted.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/codeword_framer.sv
// Serialises buffered codewords MSB first, each behind a sync header.
// Back-to-back frames run with no idle bit when the FIFO has data.
module codeword_framer
  import framer_pkg::*;
#(
  parameter int                CW_W         = DEF_CW_W,
  parameter int                SYNC_W       = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
  parameter int                FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int                CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW_W-1:0]  cw_data,
  input  logic             cw_valid,
  output logic             cw_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             sof,
  output logic             eof,
  output logic [CNT_W-1:0] frame_count,
  output logic             busy
);

  localparam int MAX_W = (CW_W > SYNC_W) ? CW_W : SYNC_W;
  localparam int IDX_W = $clog2(MAX_W);

  state_e            state;
  state_e            state_n;
  logic [SYNC_W-1:0] hdr_sr;
  logic [SYNC_W-1:0] hdr_n;
  logic [CW_W-1:0]   data_sr;
  logic [CW_W-1:0]   data_n;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;
  logic              bit_out_n;
  logic              bit_valid_n;
  logic              sof_n;
  logic              eof_n;
  logic [CNT_W-1:0]  fc_n;
  logic [CW_W-1:0]   head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              load;
  logic              xfer;

  // Ready comes from registered occupancy only; masked while in reset.
  assign cw_ready = !full && !rst;
  assign push     = cw_valid && cw_ready;
  assign xfer     = bit_valid && bit_ready;
  assign busy     = (state != IDLE) || !empty;

  sync_fifo #(
    .WIDTH (CW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cw_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_n     = state;
    hdr_n       = hdr_sr;
    data_n      = data_sr;
    idx_n       = idx;
    bit_out_n   = bit_out;
    bit_valid_n = bit_valid;
    sof_n       = sof;
    eof_n       = eof;
    fc_n        = frame_count;
    load        = 1'b0;
    pop         = 1'b0;
    unique case (state)
      IDLE: load = !empty;
      SYNC: begin
        if (xfer) begin
          sof_n = 1'b0;
          if (idx == IDX_W'(SYNC_W-1)) begin
            state_n   = DATA;
            idx_n     = '0;
            bit_out_n = data_sr[CW_W-1];
          end else begin
            hdr_n     = hdr_sr << 1;
            idx_n     = idx + 1'b1;
            bit_out_n = hdr_sr[SYNC_W-2];
          end
        end
      end
      DATA: begin
        if (xfer) begin
          if (eof) begin
            fc_n  = frame_count + 1'b1;
            eof_n = 1'b0;
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_n     = IDLE;
              bit_valid_n = 1'b0;
              bit_out_n   = 1'b0;
            end
          end else begin
            data_n    = data_sr << 1;
            idx_n     = idx + 1'b1;
            bit_out_n = data_sr[CW_W-2];
            eof_n     = (idx == IDX_W'(CW_W-2));
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Frame start, either from IDLE or straight after an eof.
    if (load) begin
      pop         = 1'b1;
      state_n     = SYNC;
      hdr_n       = SYNC_PATTERN;
      data_n      = head;
      idx_n       = '0;
      bit_out_n   = SYNC_PATTERN[SYNC_W-1];
      bit_valid_n = 1'b1;
      sof_n       = 1'b1;
      eof_n       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hdr_sr      <= '0;
      data_sr     <= '0;
      idx         <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      hdr_sr      <= hdr_n;
      data_sr     <= data_n;
      idx         <= idx_n;
      bit_out     <= bit_out_n;
      bit_valid   <= bit_valid_n;
      sof         <= sof_n;
      eof         <= eof_n;
      frame_count <= fc_n;
    end
  end

endmodule

// File: tb/tb_codeword_framer.sv
// Scoreboard bench: queued frames model the serial stream bit by bit.
// Small frame counter so the wrap is reached in a short run.
module tb_codeword_framer;

  localparam int CW_W   = 32;
  localparam int SYNC_W = 8;
  localparam int CNT_W  = 4;
  localparam int FLEN   = SYNC_W + CW_W;
  localparam logic [SYNC_W-1:0] SYNC_PAT = 8'hB8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CW_W-1:0]  cw_data = '0;
  logic             cw_valid = 1'b0;
  logic             cw_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             sof;
  logic             eof;
  logic [CNT_W-1:0] frame_count;
  logic             busy;

  always #5 clk = ~clk;

  codeword_framer #(
    .CW_W         (CW_W),
    .SYNC_W       (SYNC_W),
    .SYNC_PATTERN (SYNC_PAT),
    .FIFO_DEPTH   (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cw_data     (cw_data),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .sof         (sof),
    .eof         (eof),
    .frame_count (frame_count),
    .busy        (busy)
  );

  typedef struct {
    logic [CW_W-1:0] word;
    int              push_cyc;
  } frame_t;

  frame_t           fq[$];
  int               cyc = 0;
  int               tests = 0;
  int               fails = 0;
  bit               in_frame = 1'b0;
  int               mon_idx = 0;
  int               last_eof = 0;
  int               occ;
  logic [CNT_W-1:0] exp_fc = '0;
  int               rdy_mode = 0;
  int               rdy_step = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [CW_W-1:0] w,
                                   input int i);
    logic [SYNC_W-1:0] p;
    p = SYNC_PAT;
    if (i < SYNC_W) return p[SYNC_W-1-i];
    return w[CW_W-1-(i-SYNC_W)];
  endfunction

  function automatic int start_of(input frame_t f);
    int s;
    s = f.push_cyc + 1;
    return (s > last_eof) ? s : last_eof;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("cw_ready_in_rst", cw_ready, 0);
      fq.delete();
      in_frame = 1'b0;
      mon_idx  = 0;
      last_eof = 0;
      exp_fc   = '0;
    end else begin
      check("frame_count", frame_count, exp_fc);
      if (!in_frame && fq.size() > 0) begin
        if (start_of(fq[0]) <= cyc) begin
          in_frame = 1'b1;
          mon_idx  = 0;
        end
      end
      occ = 0;
      foreach (fq[i]) if (fq[i].push_cyc <= cyc) occ++;
      if (in_frame) occ--;
      check("cw_ready", cw_ready, occ < 2);
      check("busy", busy, in_frame || occ > 0);
      check("bit_valid", bit_valid, in_frame);
      if (in_frame) begin
        check("bit_out", bit_out, exp_bit(fq[0].word, mon_idx));
        check("sof", sof, mon_idx == 0);
        check("eof", eof, mon_idx == FLEN-1);
        if (bit_ready) begin
          mon_idx++;
          if (mon_idx == FLEN) begin
            void'(fq.pop_front());
            in_frame = 1'b0;
            mon_idx  = 0;
            last_eof = cyc + 1;
            exp_fc   = exp_fc + 1'b1;
          end
        end
      end else begin
        check("sof_idle", sof, 0);
        check("eof_idle", eof, 0);
      end
    end
  end

  initial begin
    bit_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bit_ready = 1'b1;
        1: begin
          bit_ready = (rdy_step % 4 == 0) || (rdy_step % 4 == 3);
          rdy_step++;
        end
        default: bit_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [CW_W-1:0] w);
    int n;
    n = 0;
    cw_valid = 1'b1;
    cw_data  = w;
    while (!cw_ready && n < 300) begin
      tick();
      n++;
    end
    check("push_ready", cw_ready, 1);
    if (cw_ready) begin
      fq.push_back('{w, cyc + 1});
      tick();
    end
    cw_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (fq.size() > 0 && n < 5000) begin
      tick();
      n++;
    end
    check("drain", fq.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b0;

    rdy_mode = 2;
    repeat (100) tick();

    rdy_mode = 0;
    push_word(32'hA5A5_0F0F);
    drain();

    rdy_mode = 1;
    rdy_step = 0;
    push_word(32'hA5A5_0F0F);
    drain();

    rdy_mode = 0;
    push_word(32'h1);
    push_word(32'h2);
    push_word(32'h3);
    drain();

    push_word(32'hDEAD_BEEF);
    push_word(32'h1234_5678);
    n = 0;
    while (!(in_frame && mon_idx == 19) && n < 500) begin
      tick();
      n++;
    end
    check("mid_frame_bit", mon_idx, 19);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    push_word(32'hCAFE_F00D);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      push_word($urandom);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
